keypad_scan_encoder: RTL and testbench

//   Scans a 4x4 matrix keypad, debounces key presses and encodes them as a 4-bit code.

---
 rtl/keypad_scan_encoder.sv | 165 ++++++++++++++++
 tb/tb_keypad_scan_encoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner with press/release debounce and 4-bit key encoding.
// Optional row-input synchronizer enabled by defining KEYPAD_SYNC_EN.
module keypad_scan_encoder #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_drive,
  output logic [3:0] digit,
  output logic       enter,
  output logic       key_held
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESS    = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] DB_LAST    = 16'(DEBOUNCE_CNT - 1);

  logic [3:0] rows;

`ifdef KEYPAD_SYNC_EN
  logic [3:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= row_in;
      sync2 <= sync1;
    end
  end

  assign rows = sync2;
`else
  assign rows = row_in;
`endif

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0]  col, col_n;
  logic [3:0]  row_pat, row_pat_n;
  logic [1:0]  row_idx, row_idx_n;
  logic [3:0]  digit_q, digit_n;
  logic        single_low;
  logic [1:0]  single_idx;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'd1;
      4'h1: code = 4'd2;
      4'h2: code = 4'd3;
      4'h3: code = 4'd10;
      4'h4: code = 4'd4;
      4'h5: code = 4'd5;
      4'h6: code = 4'd6;
      4'h7: code = 4'd11;
      4'h8: code = 4'd7;
      4'h9: code = 4'd8;
      4'hA: code = 4'd9;
      4'hB: code = 4'd12;
      4'hC: code = 4'd14;
      4'hD: code = 4'd0;
      4'hE: code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  // Only a pattern with exactly one low row counts as a clean single key.
  always_comb begin
    single_low = 1'b1;
    single_idx = 2'd0;
    case (rows)
      4'b1110: single_idx = 2'd0;
      4'b1101: single_idx = 2'd1;
      4'b1011: single_idx = 2'd2;
      4'b0111: single_idx = 2'd3;
      default: single_low = 1'b0;
    endcase
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    col_n     = col;
    row_pat_n = row_pat;
    row_idx_n = row_idx;
    digit_n   = digit_q;
    case (state)
      SCAN: begin
        if (cnt == DWELL_LAST) begin
          cnt_n = '0;
          if (single_low) begin
            row_pat_n = rows;
            row_idx_n = single_idx;
            state_n   = DEBOUNCE;
          end else begin
            col_n = col + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (rows != row_pat) begin
          state_n = SCAN;
          col_n   = col + 2'd1;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n = PRESS;
          cnt_n   = '0;
          digit_n = key_code(row_idx, col);
        end
      end
      PRESS: begin
        state_n = HOLD;
        cnt_n   = '0;
      end
      HOLD: begin
        if (rows != 4'b1111) begin
          cnt_n = '0;
        end else if (cnt == DB_LAST) begin
          state_n = SCAN;
          col_n   = col + 2'd1;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = SCAN;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SCAN;
      cnt     <= '0;
      col     <= '0;
      row_pat <= '1;
      row_idx <= '0;
      digit_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      col     <= col_n;
      row_pat <= row_pat_n;
      row_idx <= row_idx_n;
      digit_q <= digit_n;
    end
  end

  assign col_drive = ~(4'b0001 << col);
  assign digit     = digit_q;
  assign enter     = (state == PRESS);
  assign key_held  = (state == PRESS) || (state == HOLD);

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder: keypad matrix model plus enter/digit scoreboard.
module tb_keypad_scan_encoder;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;
`ifdef KEYPAD_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_drive;
  logic [3:0] digit;
  logic       enter;
  logic       key_held;

  logic [15:0] keys;  // bit r*4+c = key at row r, column c closed

  int checks   = 0;
  int failures = 0;
  int enter_count = 0;
  logic [3:0]  exp_q[$];
  logic        prev_enter = 1'b0;
  logic [3:0]  prev_digit = 4'd0;
  logic [15:0] lock_shift = 16'h0;

  keypad_scan_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .clk(clk), .reset(reset), .row_in(row_in),
    .col_drive(col_drive), .digit(digit), .enter(enter), .key_held(key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A closed key pulls its row low only while its column is driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_drive[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (enter === 1'b1) begin
      enter_count++;
      check("enter_expected", 16'(exp_q.size() > 0), 16'd1);
      if (exp_q.size() > 0) check("enter_digit", 16'(digit), 16'(exp_q.pop_front()));
      check("enter_not_back_to_back", 16'(prev_enter), 16'd0);
      lock_shift = {lock_shift[11:0], digit};
    end
    if (reset === 1'b0 && enter !== 1'b1 && digit !== prev_digit)
      check("digit_stable_outside_press", 16'(digit), 16'(prev_digit));
    prev_enter = enter;
    prev_digit = digit;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic release_latency(input int idx);
    int n;
    keys[idx] = 1'b0;
    n = 0;
    do begin tick(); n++; end while (key_held === 1'b1 && n < 60);
    check("release_latency", 16'(n), 16'(DEBOUNCE_CNT + SYNC_LAT));
  endtask

  task automatic press_key(input int r, input int c, input logic [3:0] code,
                           input int hold, input int extra);
    int n;
    exp_q.push_back(code);
    keys[r*4+c] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (enter !== 1'b1 && n < 200);
    check("enter_seen", 16'(enter), 16'd1);
    check("press_digit", 16'(digit), 16'(code));
    repeat (hold / 2) tick();
    if (extra >= 0) keys[extra] = 1'b1;
    repeat (hold / 4) tick();
    if (extra >= 0) keys[extra] = 1'b0;
    repeat (hold / 4) tick();
    check("key_held_during_hold", 16'(key_held), 16'd1);
    release_latency(r*4+c);
  endtask

  task automatic wait_col(input logic [3:0] pat);
    int n;
    n = 0;
    do begin tick(); n++; end while (col_drive !== pat && n < 40);
    check("col_reached", 16'(col_drive), 16'(pat));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ec;
    logic [3:0] prev_col;
    keys  = '0;
    reset = 1'b1;

    // 1: reset state
    repeat (3) tick();
    check("reset_col_drive", 16'(col_drive), 16'h000E);
    check("reset_digit", 16'(digit), 16'd0);
    check("reset_enter", 16'(enter), 16'd0);
    check("reset_key_held", 16'(key_held), 16'd0);

    // Detection latency from reset release: dwell of col 0 plus debounce
    exp_q.push_back(4'd1);
    reset = 1'b0;
    keys[0] = 1'b1;
    n = 0;
    do begin tick(); n++; end while (enter !== 1'b1 && n < 100);
    check("first_press_latency", 16'(n), 16'(SCAN_DIV + DEBOUNCE_CNT));
    repeat (20) tick();
    release_latency(0);
    repeat (10) tick();

    // 2: key '9' held 200 cycles, second key 'A' pressed meanwhile is ignored
    press_key(2, 2, 4'd9, 200, 3);
    repeat (40) tick();
    check("enters_after_9", 16'(enter_count), 16'd2);

    // 3: bouncing '5'
    for (int i = 0; i < 5; i++) begin
      keys[1*4+1] = 1'b1;
      repeat (3) tick();
      keys[1*4+1] = 1'b0;
      repeat (2) tick();
    end
    repeat (30) tick();
    check("bounce_no_enter", 16'(enter_count), 16'd2);
    check("bounce_digit", 16'(digit), 16'd9);

    // 4: rows 0 and 2 on col 1 together: treated as no key
    keys[0*4+1] = 1'b1;
    keys[2*4+1] = 1'b1;
    tick();
    prev_col = col_drive;
    for (int i = 0; i < 9; i++) begin
      n = 0;
      do begin tick(); n++; end while (col_drive === prev_col && n < 20);
      check("ghost_rotation", 16'(col_drive), 16'({prev_col[2:0], prev_col[3]}));
      if (i > 0) check("ghost_dwell", 16'(n), 16'(SCAN_DIV));
      check("ghost_no_hold", 16'(key_held), 16'd0);
      prev_col = col_drive;
    end
    keys[0*4+1] = 1'b0;
    keys[2*4+1] = 1'b0;
    check("ghost_no_enter", 16'(enter_count), 16'd2);

    // 5: '#' reset while debouncing, then strobed once after reset
    wait_col(4'b1101);
    keys[3*4+2] = 1'b1;
    wait_col(4'b1011);
    repeat (7) tick();
    check("pre_reset_no_enter", 16'(enter_count), 16'd2);
    reset = 1'b1;
    repeat (3) tick();
    check("midreset_col_drive", 16'(col_drive), 16'h000E);
    check("midreset_digit", 16'(digit), 16'd0);
    check("midreset_key_held", 16'(key_held), 16'd0);
    check("midreset_no_enter", 16'(enter_count), 16'd2);
    exp_q.push_back(4'd15);
    reset = 1'b0;
    n = 0;
    do begin tick(); n++; end while (enter !== 1'b1 && n < 200);
    check("hash_enter_seen", 16'(enter), 16'd1);
    repeat (30) tick();
    release_latency(3*4+2);
    repeat (10) tick();

    // 6: code sequence 9,9,7,9 into the lock model
    ec = enter_count;
    press_key(2, 2, 4'd9, 20, -1);
    press_key(2, 2, 4'd9, 20, -1);
    press_key(2, 0, 4'd7, 20, -1);
    press_key(2, 2, 4'd9, 20, -1);
    repeat (10) tick();
    check("sequence_enters", 16'(enter_count - ec), 16'd4);
    check("lock_unlocked", 16'(lock_shift == 16'h9979), 16'd1);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    check("total_enters", 16'(enter_count), 16'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
